serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder_digit_adder.sv | 29 ++
 rtl/serial_adder.sv | 113 +++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the digit-serial adder.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the subtract path).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit cycles needed for one operation.
  function automatic int steps(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done handshake, operands and registered results.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub select line).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             overflow;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, cin, a, b, sub, input busy, done, y, cout, overflow);
  modport slave  (input start, cin, a, b, sub, output busy, done, y, cout, overflow);
`else
  modport master (output start, cin, a, b, input busy, done, y, cout, overflow);
  modport slave  (input start, cin, a, b, output busy, done, y, cout, overflow);
`endif
endinterface

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple adder built from full-adder
// equations. Also exposes the carry into its top bit so the caller can form
// the signed overflow flag on the most significant digit.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  logic [DIGIT:0] c;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder processing DIGIT bits per clock over
// WIDTH/DIGIT cycles, carry held in a flip-flop between digits.
// Optional feature macro: SERIAL_ADDER_SUB_EN (sub=1 computes a - b).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);
  localparam int STEPS = steps(WIDTH, DIGIT);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH <= 0 || DIGIT <= 0 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $fatal(1, "serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t                 state, state_nx;
  logic [WIDTH-1:0]       sh_a, sh_b, y_r;
  logic [CNT_W-1:0]       cnt;
  logic                   carry, cout_r, ovf_r;
  logic                   accept, last;
  logic [DIGIT-1:0]       dsum;
  logic                   dcout, dcmsb;
  logic [WIDTH+DIGIT-1:0] y_cat;
  logic [WIDTH-1:0]       b_in;
  logic                   cin_in;

  // Subtraction reuses the adder: a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in   = bus.sub ? ~bus.b : bus.b;
  assign cin_in = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_in   = bus.b;
  assign cin_in = bus.cin;
`endif

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (sh_a[DIGIT-1:0]),
    .b    (sh_b[DIGIT-1:0]),
    .cin  (carry),
    .sum  (dsum),
    .cout (dcout),
    .cmsb (dcmsb)
  );

  // New digit enters at the top of y; earlier digits move down.
  assign y_cat = {dsum, y_r};
  assign last  = (cnt == CNT_W'(STEPS - 1));

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Operand latch on accept, then one digit per cycle while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a   <= '0;
      sh_b   <= '0;
      y_r    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      sh_a  <= bus.a;
      sh_b  <= b_in;
      carry <= cin_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      sh_a  <= sh_a >> DIGIT;
      sh_b  <= sh_b >> DIGIT;
      y_r   <= y_cat[WIDTH+DIGIT-1:DIGIT];
      carry <= dcout;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        cout_r <= dcout;
        ovf_r  <= dcmsb ^ dcout;
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.y        = y_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;
endmodule
